nerv_loader: RTL

Boot loader that initiates writes on the NERV data-memory bus, taking the opposite role to the memory model that answers that bus. It accepts a little-endian byte stream on a valid/ready port, packs bytes into 32-bit words, and writes them to consecutive addresses from `BASE_ADDR`. It holds the CPU in reset until the final word is committed. It sits between a host link (UART/JTAG bridge) and the memory arbiter, in front of `nerv`.

---
 rtl/nerv_loader_pkg.sv | 8 +
 rtl/nerv_loader_pack.sv | 30 +++
 rtl/nerv_loader.sv | 79 +++++++
 3 files changed

// File: rtl/nerv_loader_pkg.sv
// nerv_loader_pkg: shared states, word size and byte-lane mask for the NERV boot loader
package nerv_loader_pkg;
    typedef enum logic [2:0] {COLLECT, WRITE, READ, CHECK, DONE, ERROR} loader_state_t;
    localparam int DMEM_WORD_BYTES = 4;
    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction
endpackage

// File: rtl/nerv_loader_pack.sv
// nerv_loader_pack: packs accepted bytes little-endian into a word with strobes and a last flag
module nerv_loader_pack
    import nerv_loader_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        accept,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        word_done,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        last
);
    logic [1:0] lane;
    assign word_done = accept && (lane == 2'(DMEM_WORD_BYTES - 1) || in_last);
    // Lane 0 starts a fresh word so bytes and strobes of the previous word never leak in
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            lane  <= '0;
            wdata <= '0;
            wstrb <= '0;
            last  <= 1'b0;
        end else if (accept) begin
            lane  <= word_done ? 2'd0 : lane + 2'd1;
            wdata <= (lane == 2'd0 ? 32'd0 : wdata) | (32'(in_data) << {lane, 3'b000});
            wstrb <= (lane == 2'd0 ? 4'd0 : wstrb) | (4'd1 << lane);
            last  <= in_last;
        end
endmodule

// File: rtl/nerv_loader.sv
// nerv_loader: streams a byte image into NERV data memory; NERV_LOADER_VERIFY_EN adds read-back verify
module nerv_loader
    import nerv_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 16384
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        stall,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        dmem_valid,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [14:0] word_count
);
    loader_state_t state, state_d;
    logic          word_done, last;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [14:0]   word_idx;
    nerv_loader_pack u_pack (
        .clock     (clock),
        .resetn    (resetn),
        .accept    (in_valid && in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .word_done (word_done),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .last      (last)
    );
`ifndef NERV_LOADER_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^dmem_rdata;
`endif
    // READ revisits the word just committed, whose count has already advanced
    assign word_idx   = state == READ ? word_count - 15'd1 : word_count;
    assign dmem_addr  = BASE_ADDR + {15'd0, word_idx, 2'b00};
    assign dmem_wstrb = state == WRITE ? wstrb : 4'd0;
    assign dmem_wdata = wdata;
    assign dmem_valid = state == WRITE || state == READ;
    assign in_ready   = state == COLLECT;
    assign done       = state == DONE;
    assign error      = state == ERROR;
    assign cpu_reset  = state != DONE;
    // State register and committed-word counter
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            state      <= COLLECT;
            word_count <= '0;
        end else begin
            state <= state_d;
            if (state == WRITE && !stall) word_count <= word_count + 15'd1;
        end
    // Next-state: capacity is checked before a word ever reaches the bus
    always_comb begin
        state_d = state;
        case (state)
            COLLECT: if (word_done) state_d = word_count == 15'(MAX_WORDS) ? ERROR : WRITE;
`ifdef NERV_LOADER_VERIFY_EN
            WRITE:   if (!stall) state_d = READ;
            READ:    if (!stall) state_d = CHECK;
            CHECK:   state_d = |((dmem_rdata ^ wdata) & lane_mask(wstrb)) ? ERROR : last ? DONE : COLLECT;
`else
            WRITE:   if (!stall) state_d = last ? DONE : COLLECT;
`endif
            default: ;
        endcase
    end
endmodule
